// File: rtl/tile_ccff_chain.sv
// Configuration-chain segment: serial shadow shift register with a validated commit into cfg_out.
// Optional macro CCFF_READBACK_EN adds rb_load, which reloads the shadow from cfg_out for serial readback.
module tile_ccff_chain #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 ccff_head,
    input  logic                 ccff_shift_en,
    input  logic                 cfg_commit,
    input  logic                 rb_load,
    output logic                 ccff_tail,
    output logic [CHAIN_LEN-1:0] cfg_out,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 cfg_valid
);

    typedef enum logic [1:0] {IDLE, LOADING, FULL, COMMIT} state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0]   cfg_out_q, cfg_out_d;
    logic                   cfg_done_q, cfg_done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   cfg_valid_q, cfg_valid_d;

    logic                   commit_ok;
    logic                   rb_ok;
    logic                   rb_err;

`ifdef CCFF_READBACK_EN
    // Readback competes with commit: if both arrive together neither is honoured.
    always_comb begin
        rb_ok  = rb_load && !cfg_commit && !ccff_shift_en &&
                 ((state_q == IDLE) || (state_q == FULL));
        rb_err = rb_load && !rb_ok;
    end
    assign commit_ok = cfg_commit && !rb_load && !ccff_shift_en && (state_q == FULL);
`else
    logic unused_rb_load;
    assign unused_rb_load = rb_load;
    assign rb_ok     = 1'b0;
    assign rb_err    = 1'b0;
    assign commit_ok = cfg_commit && !ccff_shift_en && (state_q == FULL);
`endif

    always_comb begin
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        cfg_out_d   = cfg_out_q;
        cfg_valid_d = cfg_valid_q;
        cfg_done_d  = (state_q == COMMIT);
        cfg_err_d   = (cfg_commit && !commit_ok) || rb_err;

        // The copy uses the pre-shift shadow even if a new frame starts this cycle.
        if (state_q == COMMIT) begin
            cfg_out_d   = shadow_q;
            cfg_valid_d = 1'b1;
        end

        if (ccff_shift_en) begin
            shadow_d = {shadow_q[CHAIN_LEN-2:0], ccff_head};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (rb_ok) begin
            shadow_d = cfg_out_q;
            cnt_d    = CNT_FULL;
        end

        if (commit_ok) begin
            cnt_d = '0;
        end

        if (commit_ok) begin
            state_d = COMMIT;
        end else if (cnt_d == CNT_FULL) begin
            state_d = FULL;
        end else if (cnt_d == '0) begin
            state_d = IDLE;
        end else begin
            state_d = LOADING;
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            cfg_out_q   <= '0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            cfg_out_q   <= cfg_out_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign ccff_tail = shadow_q[CHAIN_LEN-1];
    assign cfg_out   = cfg_out_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_tile_ccff_chain.sv
// Directed bench for tile_ccff_chain with CHAIN_LEN=8; readback steps follow CCFF_READBACK_EN.
module tb_tile_ccff_chain;

    localparam int CL = 8;

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          cfg_commit;
    logic          rb_load;
    logic          ccff_tail;
    logic [CL-1:0] cfg_out;
    logic          cfg_done;
    logic          cfg_err;
    logic          cfg_valid;

    int tests = 0;
    int fails = 0;

    tile_ccff_chain #(.CHAIN_LEN(CL)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .cfg_commit    (cfg_commit),
        .rb_load       (rb_load),
        .ccff_tail     (ccff_tail),
        .cfg_out       (cfg_out),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .cfg_valid     (cfg_valid)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_head     = b;
        ccff_shift_en = 1'b1;
        tick();
        ccff_shift_en = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic commit_accept(input string tag, input logic [7:0] exp);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk({tag, "_done_early"}, cfg_done, 1'b0);
        tick();
        chk({tag, "_cfg_out"}, cfg_out, exp);
        chk({tag, "_done"}, cfg_done, 1'b1);
        chk({tag, "_valid"}, cfg_valid, 1'b1);
        chk({tag, "_err"}, cfg_err, 1'b0);
        tick();
        chk({tag, "_done_clr"}, cfg_done, 1'b0);
    endtask

    initial begin
        logic [11:0] seq;
        logic [7:0]  rbv;
        prog_reset    = 1'b1;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        cfg_commit    = 1'b0;
        rb_load       = 1'b0;
        #3;
        chk("rst_cfg_out", cfg_out, 8'h00);
        chk("rst_tail", ccff_tail, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        chk("rst_valid", cfg_valid, 1'b0);
        tick();
        tick();
        prog_reset = 1'b0;

        // Load 0xB2 and commit
        shift_byte(8'hB2);
        chk("b2_tail", ccff_tail, 1'b1);
        commit_accept("b2", 8'hB2);

        // Partial frame: commit rejected, then completed
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("part_err", cfg_err, 1'b1);
        chk("part_done", cfg_done, 1'b0);
        chk("part_hold", cfg_out, 8'hB2);
        tick();
        chk("part_err_clr", cfg_err, 1'b0);
        shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        commit_accept("cb", 8'hCB);

        // 12-bit pass-through: tail replays the first four bits
        seq = 12'hB2F;
        for (int i = 0; i < 12; i++) begin
            if (i >= 8) chk($sformatf("pass_tail%0d", i + 1), ccff_tail, seq[11 - (i - 8)]);
            shift_bit(seq[11 - i]);
        end
        chk("pass_hold", cfg_out, 8'hCB);
        commit_accept("2f", 8'h2F);

        // Commit with simultaneous shift in FULL is rejected, shift still happens
        shift_byte(8'h5A);
        ccff_head     = 1'b1;
        ccff_shift_en = 1'b1;
        cfg_commit    = 1'b1;
        tick();
        ccff_shift_en = 1'b0;
        cfg_commit    = 1'b0;
        chk("sim_err", cfg_err, 1'b1);
        chk("sim_done", cfg_done, 1'b0);
        chk("sim_hold", cfg_out, 8'h2F);
        tick();
        chk("sim_err_clr", cfg_err, 1'b0);

        // Accepted commit held for a second cycle: second request rejected
        cfg_commit = 1'b1;
        tick();
        chk("b2b_done_early", cfg_done, 1'b0);
        tick();
        cfg_commit = 1'b0;
        chk("b2b_cfg_out", cfg_out, 8'hB5);
        chk("b2b_done", cfg_done, 1'b1);
        chk("b2b_err", cfg_err, 1'b1);
        tick();
        chk("b2b_done_clr", cfg_done, 1'b0);
        chk("b2b_err_clr", cfg_err, 1'b0);

        // Asynchronous reset in the middle of a shift
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
        ccff_head     = 1'b1;
        ccff_shift_en = 1'b1;
        #2;
        prog_reset = 1'b1;
        #1;
        chk("arst_cfg_out", cfg_out, 8'h00);
        chk("arst_valid", cfg_valid, 1'b0);
        chk("arst_tail", ccff_tail, 1'b0);
        chk("arst_done", cfg_done, 1'b0);
        chk("arst_err", cfg_err, 1'b0);
        ccff_shift_en = 1'b0;
        tick();
        prog_reset = 1'b0;
        tick();

`ifdef CCFF_READBACK_EN
        rbv = 8'hB2;
        shift_byte(rbv);
        commit_accept("rb_b2", rbv);
        shift_bit(1'b0);
        chk("rb_loading_tail", ccff_tail, 1'b0);
        rb_load = 1'b1;
        tick();
        rb_load = 1'b0;
        chk("rb_loading_err", cfg_err, 1'b1);
        chk("rb_loading_noload", ccff_tail, 1'b0);
        tick();
        chk("rb_loading_err_clr", cfg_err, 1'b0);
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        rb_load = 1'b1;
        tick();
        rb_load = 1'b0;
        chk("rb_full_err", cfg_err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rb_tail%0d", i), ccff_tail, rbv[7 - i]);
            shift_bit(1'b0);
        end
        rb_load    = 1'b1;
        cfg_commit = 1'b1;
        tick();
        rb_load    = 1'b0;
        cfg_commit = 1'b0;
        chk("rb_both_err", cfg_err, 1'b1);
        chk("rb_both_noload", ccff_tail, 1'b0);
        tick();
        chk("rb_both_done", cfg_done, 1'b0);
        chk("rb_both_hold", cfg_out, rbv);
`else
        rbv = 8'h81;
        rb_load = 1'b1;
        tick();
        rb_load = 1'b0;
        chk("rbign_err", cfg_err, 1'b0);
        chk("rbign_tail", ccff_tail, 1'b0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("rbign_idle_commit_err", cfg_err, 1'b1);
        chk("rbign_cfg_out", cfg_out, 8'h00);
        tick();
        shift_byte(rbv);
        chk("rbign_tail_after", ccff_tail, 1'b1);
        commit_accept("rbign_81", rbv);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tile_ccff_chain.md
# tile_ccff_chain

Parametrised configuration-chain segment for a fabric tile: shifts configuration bits from `ccff_head` to `ccff_tail` on `prog_clk` and holds them in a shadow shift register. Active configuration `cfg_out` is updated only by a validated commit, so routing muxes never see partially shifted data. Every tile wrapper instantiates one; tiles daisy-chain tail-to-head across the fabric.

## Interface
- `CHAIN_LEN`, 64: configuration bits owned by this tile (≥2).
- `CNT_W`, $clog2(CHAIN_LEN+1): bit-counter width.
- `prog_clk`  in  1  configuration clock; all state on rising edge.
- `prog_reset`  in  1  reset, asynchronous, active-high.
- `ccff_head`  in  1  serial config data in.
- `ccff_shift_en`  in  1  shift enable; one bit per cycle while high.
- `cfg_commit`  in  1  single-cycle request to copy shadow to active.
- `rb_load`  in  1  readback load (used only with `CCFF_READBACK_EN`).
- `ccff_tail`  out  1  serial data out = shadow[CHAIN_LEN-1].
- `cfg_out`  out  CHAIN_LEN  active configuration to tile muxes.
- `cfg_done`  out  1  one-cycle pulse, commit accepted.
- `cfg_err`  out  1  one-cycle pulse, commit or readback rejected.
- `cfg_valid`  out  1  sticky; high after first accepted commit.

## Operation
- Shift: when `ccff_shift_en`=1, shadow <= {shadow[CHAIN_LEN-2:0], ccff_head}; first bit shifted in reaches bit CHAIN_LEN-1 after CHAIN_LEN shifts.
- Counter `cnt` increments per shift, saturates at CHAIN_LEN (pass-through bits for downstream tiles keep it saturated; shadow holds the last CHAIN_LEN bits).
- FSM states:
  - IDLE: cnt=0. Shift -> LOADING (or FULL if CHAIN_LEN reached).
  - LOADING: 0<cnt<CHAIN_LEN. cnt reaches CHAIN_LEN -> FULL.
  - FULL: cnt=CHAIN_LEN. Accepted commit -> COMMIT.
  - COMMIT: one cycle; cfg_out <= shadow, cfg_done=1, cfg_valid<=1, cnt<=0; -> IDLE. Shadow contents retained.
- Commit acceptance: `cfg_commit`=1 in FULL with `ccff_shift_en`=0. Otherwise (IDLE, LOADING, COMMIT, or simultaneous shift) commit is rejected: cfg_err pulses next cycle, cfg_out unchanged, state unchanged, shift (if any) still performed.
- `rb_load` with macro off: ignored, no error.
- Reset mid-shift or mid-commit: asynchronous clear; partial frame discarded, cfg_out returns to 0.

## Timing
- Reset values: shadow=0, cfg_out=0, ccff_tail=0, cfg_done=0, cfg_err=0, cfg_valid=0, cnt=0, state IDLE.
- Head-to-tail latency: CHAIN_LEN cycles of `ccff_shift_en`; ccff_tail is a registered bit, no combinational head->tail path.
- Commit latency: cfg_commit sampled at edge N; cfg_out, cfg_done, cfg_valid change after edge N+1 (COMMIT state); cfg_done high exactly one cycle.
- cfg_err asserted for the cycle after the rejected request, one cycle wide.
- Back-to-back commit in COMMIT cycle rejected (cnt already cleared).
- cfg_out stable between commits regardless of shift activity.

## Configuration
- `CCFF_READBACK_EN` defined: `rb_load`=1 in IDLE or FULL with `ccff_shift_en`=0 loads shadow <= cfg_out, cnt <= CHAIN_LEN, state -> FULL, so subsequent CHAIN_LEN shifts emit active config on ccff_tail (bit CHAIN_LEN-1 first). rb_load in LOADING/COMMIT or with shift_en=1: rejected, cfg_err pulse, no load. rb_load and cfg_commit together: both rejected.
- Undefined: readback logic absent, `rb_load` ignored, shadow only written by shifting.

## Test plan
- CHAIN_LEN=8: reset, shift 8'b1011_0010 MSB first, commit -> cfg_out=8'hB2 one cycle after commit sample, cfg_done 1-cycle pulse, cfg_valid=1.
- Shift 5 bits then commit -> cfg_err pulse, cfg_out holds prior 8'hB2, state LOADING, 3 more shifts then commit accepted.
- Shift 12 bits (0xB2 then 4'hF), commit -> cfg_out=8'h2F; ccff_tail during shifts 9-12 reproduces first four bits 1,0,1,1.
- cfg_commit with ccff_shift_en=1 in FULL -> cfg_err, shift performed, cfg_out unchanged; prog_reset asserted mid-shift -> all outputs 0 immediately, no clock needed.
- With `CCFF_READBACK_EN`: after committing 8'hB2, rb_load then 8 shifts with head=0 -> ccff_tail yields 1,0,1,1,0,0,1,0; rb_load during LOADING -> cfg_err, no load.
- Without macro: rb_load pulse in IDLE -> no cfg_err, shadow and state unchanged.
